// File: rtl/approx_arb_pkg.sv
// Shared types, widths and the round-robin search helper for the approximate-adder arbiter.
package approx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam int NIB_W   = 4;
  localparam int SUM_W   = 5;
  localparam int MAX_REQ = 16;
  localparam int IDX_W   = 4;

  // Returns {found, index}: first set bit of valid searching ptr..nreq-1, then 0..ptr-1.
  function automatic logic [IDX_W:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                             input logic [IDX_W-1:0]   ptr,
                                             input int                 nreq);
    logic [IDX_W:0] res;
    int             idx;
    res = {1'b0, {IDX_W{1'b0}}};
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % nreq;
      if ((k < nreq) && !res[IDX_W] && valid[idx]) begin
        res = {1'b1, idx[IDX_W-1:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/approx.sv
// 4-bit approximate adder: the low p bits are OR-ed, the rest is an exact ripple add
// whose carry-in is a[p-1]&b[p-1].
module approx
  import approx_arb_pkg::*;
#(
  parameter int p = 2
) (
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  output logic [SUM_W-1:0] sum
);

  logic [SUM_W-1:0] sum_s;
  logic             c_s;

  // In the OR region the carry variable only remembers a[i]&b[i] of the top approximated bit.
  always_comb begin
    sum_s = {SUM_W{1'b0}};
    c_s   = 1'b0;
    for (int i = 0; i < NIB_W; i++) begin
      if (i < p) begin
        sum_s[i] = a[i] | b[i];
        c_s      = a[i] & b[i];
      end else begin
        sum_s[i] = a[i] ^ b[i] ^ c_s;
        c_s      = (a[i] & b[i]) | (c_s & (a[i] ^ b[i]));
      end
    end
    sum_s[NIB_W] = c_s;
  end

  assign sum = sum_s;

endmodule

// File: rtl/approx_add_arbiter.sv
// Round-robin arbiter sharing one approximate adder between NREQ requesters:
// grant + operand capture, one add, then a held response tagged with the requester id.
module approx_add_arbiter
  import approx_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int P    = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NIB_W*NREQ-1:0] req_a,
  input  logic [NIB_W*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [SUM_W-1:0]      rsp_sum,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [NIB_W-1:0]   a_q, a_d, b_q, b_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [SUM_W-1:0]   rsp_sum_q, rsp_sum_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic               busy_q, busy_d;

  logic [MAX_REQ-1:0] valid_ext_s;
  logic [IDX_W:0]     pick_s;
  logic               found_s;
  logic [IDW-1:0]     win_s;
  logic [NREQ-1:0]    req_ready_s;
  logic [SUM_W-1:0]   add_sum_s;

  approx #(.p(P)) u_approx (
    .a   (a_q),
    .b   (b_q),
    .sum (add_sum_s)
  );

  // Round-robin winner search starting at rr_ptr.
  always_comb begin
    valid_ext_s             = {MAX_REQ{1'b0}};
    valid_ext_s[NREQ-1:0]   = req_valid;
    pick_s                  = rr_pick(valid_ext_s, IDX_W'(rr_ptr_q), NREQ);
    found_s                 = pick_s[IDX_W];
    win_s                   = IDW'(pick_s[IDX_W-1:0]);
  end

  // One-hot grant, only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready_s = {NREQ{1'b0}};
    if (rst_n && (state_q == IDLE) && found_s) begin
      req_ready_s[win_s] = 1'b1;
    end else begin
      req_ready_s = {NREQ{1'b0}};
    end
  end

  // Next-state and datapath updates for IDLE -> CALC -> RESP -> IDLE.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          a_d     = req_a[win_s*NIB_W +: NIB_W];
          b_d     = req_b[win_s*NIB_W +: NIB_W];
          id_d    = win_s;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rsp_sum_d   = add_sum_s;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (id_q == IDW'(NREQ - 1)) ? {IDW{1'b0}} : id_q + {{(IDW-1){1'b0}}, 1'b1};
          state_d     = IDLE;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, captured operands and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= {IDW{1'b0}};
      id_q        <= {IDW{1'b0}};
      a_q         <= {NIB_W{1'b0}};
      b_q         <= {NIB_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= {SUM_W{1'b0}};
      rsp_id_q    <= {IDW{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Randomized bench for approx_add_arbiter: two instances (P=2, P=0) share stimulus and are
// compared each cycle against a transaction-level model of the arbitration and arithmetic.
module tb_approx_add_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [4*NREQ-1:0]   req_a, req_b;
  logic                rsp_ready;
  logic [NREQ-1:0]     req_ready, req_ready0;
  logic                rsp_valid, rsp_valid0, busy, busy0;
  logic [4:0]          rsp_sum, rsp_sum0;
  logic [IDW-1:0]      rsp_id, rsp_id0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  approx_add_arbiter #(.NREQ(NREQ), .P(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id), .busy(busy)
  );

  approx_add_arbiter #(.NREQ(NREQ), .P(0)) dut_p0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum0), .rsp_id(rsp_id0), .busy(busy0)
  );

  // Requester-side view
  logic       pend_v [NREQ];
  logic [3:0] pend_a [NREQ];
  logic [3:0] pend_b [NREQ];
  int         refill_mode;   // 0 none, 1 random new requests, 2 re-raise immediately
  int         rdy_mode;      // 0 random, 1 always ready, 2 never ready

  // Model: phase 0 idle, 1 computing, 2 response pending
  int m_phase, m_ptr, m_id, m_a, m_b, cyc;
  int grant_log[$];
  int grant_cyc[$];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int ref_sum(input int a, input int b, input int p);
    int low, hi, c;
    low = (a | b) & ((1 << p) - 1);
    c   = (p > 0) ? ((a >> (p - 1)) & (b >> (p - 1)) & 1) : 0;
    hi  = ((a >> p) + (b >> p) + c) << p;
    return hi | low;
  endfunction

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      if (pend_v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = pend_v[i];
      req_a[4*i +: 4]    = pend_a[i];
      req_b[4*i +: 4]    = pend_b[i];
    end
  endtask

  task automatic set_req(input int i, input int a, input int b);
    pend_v[i] = 1'b1;
    pend_a[i] = 4'(a);
    pend_b[i] = 4'(b);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
  endtask

  // One clock cycle: entered and left just after a falling edge.
  task automatic step();
    int w, exp_ready;
    for (int i = 0; i < NREQ; i++) begin
      if (!pend_v[i] && ((refill_mode == 2) || (refill_mode == 1 && $urandom_range(0, 2) == 0)))
        set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    rsp_ready = (rdy_mode == 0) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    drive();
    #1;
    w         = (m_phase == 0) ? pick() : -1;
    exp_ready = (w >= 0) ? (1 << w) : 0;
    check_eq("req_ready",    int'(req_ready),  exp_ready);
    check_eq("req_ready_p0", int'(req_ready0), exp_ready);
    check_eq("rsp_valid",    int'(rsp_valid),  int'(m_phase == 2));
    check_eq("rsp_valid_p0", int'(rsp_valid0), int'(m_phase == 2));
    check_eq("busy",         int'(busy),       int'(m_phase != 0));
    if (m_phase == 2) begin
      check_eq("rsp_sum_p2", int'(rsp_sum),  ref_sum(m_a, m_b, 2));
      check_eq("rsp_sum_p0", int'(rsp_sum0), ref_sum(m_a, m_b, 0));
      check_eq("rsp_id",     int'(rsp_id),   m_id);
    end
    case (m_phase)
      0: if (w >= 0) begin
           m_id = w; m_a = int'(pend_a[w]); m_b = int'(pend_b[w]);
           pend_v[w] = 1'b0;
           grant_log.push_back(w);
           grant_cyc.push_back(cyc);
           m_phase = 1;
         end
      1: m_phase = 2;
      2: if (rsp_ready) begin m_ptr = (m_id + 1) % NREQ; m_phase = 0; end
      default: m_phase = 0;
    endcase
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int s, k;
    rst_n = 1'b1; rsp_ready = 1'b0; cyc = 0;
    m_phase = 0; m_ptr = 0; m_id = 0; m_a = 0; m_b = 0;
    refill_mode = 0; rdy_mode = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, i + 3, 15 - i);
    drive();
    #1 rst_n = 1'b0;

    // Reset with every request asserted
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_req_ready", int'(req_ready), 0);
    check_eq("rst_rsp_valid", int'(rsp_valid), 0);
    check_eq("rst_busy",      int'(busy),      0);
    check_eq("rst_rsp_sum",   int'(rsp_sum),   0);
    check_eq("rst_rsp_id",    int'(rsp_id),    0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 1: 7 + 1
    clear_reqs();
    set_req(1, 7, 1);
    repeat (5) step();
    check_eq("t2_grant", grant_log[grant_log.size()-1], 1);

    // Operands that overflow into the carry bit
    set_req(2, 15, 15);
    repeat (5) step();

    // All requests held: strict rotation, one grant every 3 cycles
    s = grant_log.size();
    refill_mode = 2;
    repeat (16) step();
    refill_mode = 0;
    check_eq("t4_count", int'(grant_log.size() - s >= 5), 1);
    for (int j = s + 1; j < grant_log.size(); j++) begin
      check_eq("t4_order", grant_log[j], (grant_log[j-1] + 1) % NREQ);
      check_eq("t4_gap",   grant_cyc[j] - grant_cyc[j-1], 3);
    end

    // Backpressure in RESP
    for (int i = 0; i < NREQ; i++) set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    k = 0;
    while (m_phase != 2 && k < 10) begin step(); k++; end
    check_eq("t5_reach_resp", m_phase, 2);
    s = grant_log.size();
    rdy_mode = 2;
    repeat (5) step();
    check_eq("t5_no_grant", grant_log.size() - s, 0);
    rdy_mode = 1;
    repeat (5) step();
    check_eq("t5_next_grant", int'(grant_log.size() > s), 1);

    // Reset while computing
    clear_reqs();
    repeat (4) step();
    set_req(2, 9, 6);
    k = 0;
    while (m_phase != 1 && k < 10) begin step(); k++; end
    check_eq("t6_reach_calc", m_phase, 1);
    rst_n = 1'b0;
    m_phase = 0; m_ptr = 0;
    for (int i = 0; i < NREQ; i++) set_req(i, i, i + 8);
    drive();
    repeat (3) begin
      #1;
      check_eq("t6_rsp_valid", int'(rsp_valid), 0);
      check_eq("t6_busy",      int'(busy),      0);
      check_eq("t6_req_ready", int'(req_ready), 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    step();
    check_eq("t6_first_grant", grant_log[grant_log.size()-1], 0);
    repeat (4) step();

    // Random traffic with random backpressure
    refill_mode = 1; rdy_mode = 0;
    repeat (300) step();
    refill_mode = 0; rdy_mode = 1;
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
